// File: rtl/harq_combine_pkg.sv
// Shared types and constants for the HARQ soft-combine engine.
package harq_combine_pkg;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_READ    = 5'b00010,
        ST_DRAIN   = 5'b00100,
        ST_COMP    = 5'b01000,
        ST_WAITLOW = 5'b10000
    } state_t;

    localparam int LLR_MAX  = 127;
    localparam int LLR_MIN  = -127;
    localparam int USER_AW  = 3;
    localparam int CB_LEN_W = 9;

    localparam logic [3:0] USER_IDX_INVALID = 4'hf;

    function automatic logic user_valid(input logic [3:0] idx);
        return (idx != USER_IDX_INVALID) && !idx[3];
    endfunction

endpackage

// File: rtl/llr_sat_add.sv
// One-lane signed LLR add, clipped to the symmetric range [LLR_MIN, LLR_MAX].
module llr_sat_add
    import harq_combine_pkg::*;
#(
    parameter int LLR_W = 8
) (
    input  logic signed [LLR_W-1:0] i_a,
    input  logic signed [LLR_W-1:0] i_b,
    output logic signed [LLR_W-1:0] o_sum
);

    localparam logic signed [LLR_W:0] SUM_MAX = (LLR_W+1)'(LLR_MAX);
    localparam logic signed [LLR_W:0] SUM_MIN = (LLR_W+1)'(LLR_MIN);

    logic signed [LLR_W:0] sum;

    always_comb begin
        sum = {i_a[LLR_W-1], i_a} + {i_b[LLR_W-1], i_b};
        if (sum > SUM_MAX) begin
            o_sum = SUM_MAX[LLR_W-1:0];
        end else if (sum < SUM_MIN) begin
            o_sum = SUM_MIN[LLR_W-1:0];
        end else begin
            o_sum = sum[LLR_W-1:0];
        end
    end

endmodule

// File: rtl/harq_combine_engine.sv
// Per-user HARQ combine: reads the ready input-buffer half, soft-combines with
// the HARQ cache lane by lane, writes back and pulses a completion.
module harq_combine_engine
    import harq_combine_pkg::*;
#(
    parameter int LLR_W      = 8,
    parameter int LANES      = 6,
    parameter int DATA_WIDTH = 48,
    parameter int USER_NUM   = 8,
    parameter int WORD_AW    = 8
) (
    input  logic                           i_core_clk,
    input  logic                           i_rx_rstn,
    input  logic                           i_rx_fsm_rstn,
    input  logic                           i_combine_process_request,
    input  logic [3:0]                     i_combine_user_index,
    input  logic [USER_NUM-1:0]            i_pingpong_indicator,
    input  logic [USER_NUM-1:0]            i_first_tx,
    input  logic [CB_LEN_W*USER_NUM-1:0]   i_user_cb_len,
    output logic                           o_ib_rd_en,
    output logic [WORD_AW+USER_AW:0]       o_ib_rd_addr,
    input  logic [DATA_WIDTH-1:0]          i_ib_rd_data,
    output logic                           o_hc_rd_en,
    output logic [WORD_AW+USER_AW-1:0]     o_hc_rd_addr,
    input  logic [DATA_WIDTH-1:0]          i_hc_rd_data,
    output logic                           o_hc_wr_en,
    output logic [WORD_AW+USER_AW-1:0]     o_hc_wr_addr,
    output logic [DATA_WIDTH-1:0]          o_hc_wr_data,
    output logic                           o_current_cb_combine_comp,
    output logic                           o_combine_err
);

    logic rst_n;
    assign rst_n = i_rx_rstn & i_rx_fsm_rstn;

    state_t                state_q, state_d;
    logic [USER_AW-1:0]    user_q, user_d;
    logic [CB_LEN_W-1:0]   len_q, len_d;
    logic                  pp_q, pp_d, first_q, first_d;
    logic [CB_LEN_W-1:0]   cnt_q, cnt_d;
    logic                  rd_en_q, rd_en_d, hc_rd_en_q, hc_rd_en_d;
    logic [WORD_AW-1:0]    rd_word_q, rd_word_d;
    logic                  v1_q, v1_d;
    logic [WORD_AW-1:0]    word1_q, word1_d;
    logic                  wr_en_q, wr_en_d;
    logic [WORD_AW-1:0]    wr_word_q, wr_word_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  comp_q, comp_d, err_q, err_d;

    logic [USER_AW-1:0]    user_sel;
    logic [CB_LEN_W-1:0]   len_sel;
    logic [DATA_WIDTH-1:0] sum_word;

    assign user_sel = i_combine_user_index[USER_AW-1:0];
    assign len_sel  = i_user_cb_len[CB_LEN_W*int'(user_sel) +: CB_LEN_W];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        llr_sat_add #(.LLR_W(LLR_W)) u_add (
            .i_a   (i_ib_rd_data[k*LLR_W +: LLR_W]),
            .i_b   (i_hc_rd_data[k*LLR_W +: LLR_W]),
            .o_sum (sum_word[k*LLR_W +: LLR_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        user_d     = user_q;
        len_d      = len_q;
        pp_d       = pp_q;
        first_d    = first_q;
        cnt_d      = cnt_q;
        rd_en_d    = 1'b0;
        hc_rd_en_d = 1'b0;
        rd_word_d  = rd_word_q;
        comp_d     = 1'b0;
        err_d      = err_q;
        // Read-data pipeline: the valid/address pair trails the read by one
        // cycle so it lines up with RAM data, then the sum is registered.
        v1_d       = rd_en_q;
        word1_d    = rd_word_q;
        wr_en_d    = v1_q;
        wr_word_d  = word1_q;
        wr_data_d  = first_q ? i_ib_rd_data : sum_word;

        case (state_q)
            ST_IDLE: begin
                if (i_combine_process_request) begin
                    user_d  = user_sel;
                    len_d   = len_sel;
                    pp_d    = i_pingpong_indicator[user_sel];
                    first_d = i_first_tx[user_sel];
                    if (!user_valid(i_combine_user_index)) begin
                        err_d   = 1'b1;
                        comp_d  = 1'b1;
                        state_d = ST_COMP;
                    end else if (len_sel == '0) begin
                        comp_d  = 1'b1;
                        state_d = ST_COMP;
                    end else begin
                        rd_en_d    = 1'b1;
                        hc_rd_en_d = !i_first_tx[user_sel];
                        rd_word_d  = '0;
                        cnt_d      = CB_LEN_W'(1);
                        state_d    = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q < len_q) begin
                    rd_en_d    = 1'b1;
                    hc_rd_en_d = !first_q;
                    rd_word_d  = cnt_q[WORD_AW-1:0];
                    cnt_d      = cnt_q + CB_LEN_W'(1);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!v1_q) begin
                    comp_d  = 1'b1;
                    state_d = ST_COMP;
                end
            end
            ST_COMP: begin
                state_d = ST_WAITLOW;
            end
            ST_WAITLOW: begin
                if (!i_combine_process_request) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            user_q     <= '0;
            len_q      <= '0;
            pp_q       <= 1'b0;
            first_q    <= 1'b0;
            cnt_q      <= '0;
            rd_en_q    <= 1'b0;
            hc_rd_en_q <= 1'b0;
            rd_word_q  <= '0;
            v1_q       <= 1'b0;
            word1_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_word_q  <= '0;
            wr_data_q  <= '0;
            comp_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            user_q     <= user_d;
            len_q      <= len_d;
            pp_q       <= pp_d;
            first_q    <= first_d;
            cnt_q      <= cnt_d;
            rd_en_q    <= rd_en_d;
            hc_rd_en_q <= hc_rd_en_d;
            rd_word_q  <= rd_word_d;
            v1_q       <= v1_d;
            word1_q    <= word1_d;
            wr_en_q    <= wr_en_d;
            wr_word_q  <= wr_word_d;
            wr_data_q  <= wr_data_d;
            comp_q     <= comp_d;
            err_q      <= err_d;
        end
    end

    assign o_ib_rd_en                = rd_en_q;
    assign o_ib_rd_addr              = {pp_q, user_q, rd_word_q};
    assign o_hc_rd_en                = hc_rd_en_q;
    assign o_hc_rd_addr              = {user_q, rd_word_q};
    assign o_hc_wr_en                = wr_en_q;
    assign o_hc_wr_addr              = {user_q, wr_word_q};
    assign o_hc_wr_data              = wr_data_q;
    assign o_current_cb_combine_comp = comp_q;
    assign o_combine_err             = err_q;

endmodule

// File: tb/tb_harq_combine_engine.sv
// Directed bench for harq_combine_engine with RAM models and a write/read scoreboard.
module tb_harq_combine_engine;

    logic        clk = 1'b0;
    logic        i_rx_rstn, i_rx_fsm_rstn;
    logic        req;
    logic [3:0]  idx;
    logic [7:0]  pp, first;
    logic [71:0] cb_len;
    logic        o_ib_rd_en, o_hc_rd_en, o_hc_wr_en, o_comp, o_err;
    logic [11:0] o_ib_rd_addr;
    logic [10:0] o_hc_rd_addr, o_hc_wr_addr;
    logic [47:0] ib_rd_data, hc_rd_data, o_hc_wr_data;

    logic [47:0] ib_mem [0:4095];
    logic [47:0] hc_mem [0:2047];

    logic [63:0] q_ib[$];
    logic [63:0] q_hc[$];
    logic [63:0] q_wa[$];
    logic [63:0] q_wd[$];

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc = 0;
    int ib_cnt = 0, hc_cnt = 0, wr_cnt = 0, comp_cnt = 0;

    harq_combine_engine #(
        .LLR_W(8), .LANES(6), .DATA_WIDTH(48), .USER_NUM(8), .WORD_AW(8)
    ) dut (
        .i_core_clk                (clk),
        .i_rx_rstn                 (i_rx_rstn),
        .i_rx_fsm_rstn             (i_rx_fsm_rstn),
        .i_combine_process_request (req),
        .i_combine_user_index      (idx),
        .i_pingpong_indicator      (pp),
        .i_first_tx                (first),
        .i_user_cb_len             (cb_len),
        .o_ib_rd_en                (o_ib_rd_en),
        .o_ib_rd_addr              (o_ib_rd_addr),
        .i_ib_rd_data              (ib_rd_data),
        .o_hc_rd_en                (o_hc_rd_en),
        .o_hc_rd_addr              (o_hc_rd_addr),
        .i_hc_rd_data              (hc_rd_data),
        .o_hc_wr_en                (o_hc_wr_en),
        .o_hc_wr_addr              (o_hc_wr_addr),
        .o_hc_wr_data              (o_hc_wr_data),
        .o_current_cb_combine_comp (o_comp),
        .o_combine_err             (o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_ib_rd_en) ib_rd_data <= ib_mem[o_ib_rd_addr];
        if (o_hc_rd_en) hc_rd_data <= hc_mem[o_hc_rd_addr];
        if (o_hc_wr_en) hc_mem[o_hc_wr_addr] <= o_hc_wr_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] fill6(input int base, input int step);
        logic [47:0] r;
        int v;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            v = base + k * step;
            r[8*k +: 8] = v[7:0];
        end
        return r;
    endfunction

    function automatic logic [47:0] model(input logic [47:0] ib, input logic [47:0] hc, input bit fst);
        logic [47:0] r;
        int a, b, s;
        if (fst) return ib;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            a = int'($signed(ib[8*k +: 8]));
            b = int'($signed(hc[8*k +: 8]));
            s = a + b;
            if (s > 127)  s = 127;
            if (s < -127) s = -127;
            r[8*k +: 8] = s[7:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        logic [63:0] e, e2;
        if (o_ib_rd_en) begin
            ib_cnt++;
            e = 'x;
            if (q_ib.size() > 0) e = q_ib.pop_front();
            chk("ib_rd_addr", 64'(o_ib_rd_addr), e);
        end
        if (o_hc_rd_en) begin
            hc_cnt++;
            e = 'x;
            if (q_hc.size() > 0) e = q_hc.pop_front();
            chk("hc_rd_addr", 64'(o_hc_rd_addr), e);
        end
        if (o_hc_wr_en) begin
            wr_cnt++;
            e = 'x;
            e2 = 'x;
            if (q_wa.size() > 0) begin
                e  = q_wa.pop_front();
                e2 = q_wd.pop_front();
            end
            chk("hc_wr_addr", 64'(o_hc_wr_addr), e);
            chk("hc_wr_data", 64'(o_hc_wr_data), e2);
        end
        if (o_comp) comp_cnt++;
    end

    task automatic push_exp(input logic [2:0] u, input int len);
        logic [11:0] ia;
        logic [10:0] ha;
        for (int w = 0; w < len; w++) begin
            ia = {pp[u], u, 8'(w)};
            ha = {u, 8'(w)};
            q_ib.push_back(64'(ia));
            if (!first[u]) q_hc.push_back(64'(ha));
            q_wa.push_back(64'(ha));
            q_wd.push_back(64'(model(ib_mem[ia], hc_mem[ha], first[u])));
        end
    endtask

    task automatic do_op(input logic [3:0] ui, input int exp_lat, input int hold, input bit drop);
        int t0, lat, len, ib0, hc0, wr0, c0;
        bit got, valid;
        logic [2:0] u;
        @(negedge clk);
        #1;
        u = ui[2:0];
        valid = (ui < 4'd8);
        len = valid ? int'(cb_len[9*int'(u) +: 9]) : 0;
        ib0 = ib_cnt; hc0 = hc_cnt; wr0 = wr_cnt; c0 = comp_cnt;
        if (valid) push_exp(u, len);
        idx = ui;
        req = 1'b1;
        t0 = cyc;
        if (drop) begin
            @(posedge clk);
            #1 req = 1'b0;
        end
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (o_comp) begin
                got = 1'b1;
                lat = cyc - t0;
                break;
            end
        end
        chk("comp_seen", 64'(got), 64'd1);
        chk("comp_latency", 64'(lat), 64'(exp_lat));
        repeat (hold) @(negedge clk);
        #1 req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("ib_rd_count", 64'(ib_cnt - ib0), 64'(len));
        chk("hc_rd_count", 64'(hc_cnt - hc0), 64'((valid && !first[u]) ? len : 0));
        chk("wr_count", 64'(wr_cnt - wr0), 64'(len));
        chk("comp_pulses", 64'(comp_cnt - c0), 64'd1);
        chk("sb_empty", 64'(q_ib.size() + q_hc.size() + q_wa.size()), 64'd0);
    endtask

    initial begin
        i_rx_rstn = 1'b0;
        i_rx_fsm_rstn = 1'b1;
        req = 1'b0;
        idx = 4'd0;
        pp = 8'b0000_0110;
        first = 8'b0000_0001;
        cb_len = '0;
        cb_len[9*2 +: 9] = 9'd3;
        cb_len[9*5 +: 9] = 9'd1;
        cb_len[9*0 +: 9] = 9'd2;
        cb_len[9*3 +: 9] = 9'd0;
        cb_len[9*7 +: 9] = 9'd4;
        cb_len[9*1 +: 9] = 9'd200;
        for (int a = 0; a < 4096; a++) ib_mem[a] = fill6(a % 97 - 48, 7);
        for (int a = 0; a < 2048; a++) hc_mem[a] = fill6(a % 53 - 26, -5);

        repeat (3) @(negedge clk);
        chk("rst_ib_rd_en", 64'(o_ib_rd_en), 64'd0);
        chk("rst_hc_wr_en", 64'(o_hc_wr_en), 64'd0);
        chk("rst_comp", 64'(o_comp), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        i_rx_rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ib_addr", 64'(o_ib_rd_addr), 64'd0);

        // user 2, len 3, pp 1: +100 + +50 clips to +127
        ib_mem[12'hA00] = fill6(100, 0);
        ib_mem[12'hA01] = fill6(10, 10);
        ib_mem[12'hA02] = fill6(-100, 0);
        hc_mem[11'h200] = fill6(50, 0);
        hc_mem[11'h201] = fill6(50, 0);
        hc_mem[11'h202] = fill6(-50, 0);
        do_op(4'd2, 6, 0, 1'b0);
        chk("clip_pos_word", 64'(hc_mem[11'h200]), 64'(fill6(127, 0)));
        chk("err_clear", 64'(o_err), 64'd0);

        // user 5: negative clip, then mixed-sign lanes
        ib_mem[12'h500] = fill6(-100, 0);
        hc_mem[11'h500] = fill6(-100, 0);
        do_op(4'd5, 4, 0, 1'b0);
        chk("clip_neg_word", 64'(hc_mem[11'h500]), 64'(fill6(-127, 0)));
        ib_mem[12'h500] = fill6(-10, 0);
        hc_mem[11'h500] = fill6(30, 0);
        do_op(4'd5, 4, 0, 1'b0);
        chk("mixed_word", 64'(hc_mem[11'h500]), 64'(fill6(20, 0)));

        // user 0 first transmission, held request after comp
        ib_mem[12'h000] = fill6(-128, 0);
        ib_mem[12'h001] = fill6(-128, 1);
        do_op(4'd0, 5, 4, 1'b0);
        chk("first_tx_word", 64'(hc_mem[11'h000]), 64'(fill6(-128, 0)));

        // user 7 with request dropped mid-combine
        cb_len[9*2 +: 9] = 9'd50;
        do_op(4'd7, 7, 0, 1'b1);

        do_op(4'hf, 1, 0, 1'b0);
        chk("err_set", 64'(o_err), 64'd1);
        do_op(4'd3, 1, 0, 1'b0);
        chk("err_sticky", 64'(o_err), 64'd1);

        // FSM reset in the middle of a long combine
        @(negedge clk);
        #1;
        push_exp(3'd1, 200);
        idx = 4'd1;
        req = 1'b1;
        repeat (20) @(negedge clk);
        #2 i_rx_fsm_rstn = 1'b0;
        req = 1'b0;
        #1;
        chk("frst_ib_rd_en", 64'(o_ib_rd_en), 64'd0);
        chk("frst_hc_rd_en", 64'(o_hc_rd_en), 64'd0);
        chk("frst_wr_en", 64'(o_hc_wr_en), 64'd0);
        chk("frst_err", 64'(o_err), 64'd0);
        @(negedge clk);
        #2 i_rx_fsm_rstn = 1'b1;
        q_ib.delete();
        q_hc.delete();
        q_wa.delete();
        q_wd.delete();
        begin
            int w0, c0;
            w0 = wr_cnt;
            c0 = comp_cnt;
            repeat (250) @(negedge clk);
            #1;
            chk("frst_no_writes", 64'(wr_cnt - w0), 64'd0);
            chk("frst_no_comp", 64'(comp_cnt - c0), 64'd0);
        end
        cb_len[9*1 +: 9] = 9'd2;
        do_op(4'd1, 5, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
